// File: rtl/spi_bus_arbiter_pkg.sv
// spi_bus_arbiter_pkg: shared state encodings and counter sizing for the SPI bus arbiter
package spi_bus_arbiter_pkg;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_OWN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HOLD  = 3'd4
  } state_e;
  function automatic int cnt_w(input int p);
    return $clog2(p < 2 ? 2 : p) + 1;
  endfunction
endpackage

// File: rtl/spi_bus_arbiter_if.sv
// spi_bus_arbiter_if: client-side and SPI-engine-side signals of the shared SPI bus
interface spi_bus_arbiter_if #(parameter int N = 2);
  logic [N-1:0]      req;
  logic [N-1:0]      grant;
  logic [N-1:0][7:0] cli_tx_byte;
  logic [N-1:0]      cli_tx_dv;
  logic [N-1:0]      cli_tx_ready;
  logic [N-1:0]      cli_rx_dv;
  logic [7:0]        cli_rx_byte;
  logic [7:0]        spi_tx_byte;
  logic              spi_tx_dv;
  logic              spi_tx_ready;
  logic              spi_rx_dv;
  logic [7:0]        spi_rx_byte;
  logic [N-1:0]      cs_n;
  modport master (
    input  req, cli_tx_byte, cli_tx_dv, spi_tx_ready, spi_rx_dv, spi_rx_byte,
    output grant, cli_tx_ready, cli_rx_dv, cli_rx_byte, spi_tx_byte, spi_tx_dv, cs_n
  );
  modport slave (
    output req, cli_tx_byte, cli_tx_dv, spi_tx_ready, spi_rx_dv, spi_rx_byte,
    input  grant, cli_tx_ready, cli_rx_dv, cli_rx_byte, spi_tx_byte, spi_tx_dv, cs_n
  );
endinterface

// File: rtl/spi_bus_arbiter_rr_pick_n.sv
// rr_pick_n: combinational round-robin pick of the first requester after last_i
module rr_pick_n #(
  parameter  int N_CLIENTS = 2,
  localparam int IW        = $clog2(N_CLIENTS)
) (
  input  logic [N_CLIENTS-1:0] req_i,
  input  logic [IW-1:0]        last_i,
  output logic [IW-1:0]        sel_o,
  output logic                 valid_o
);
  logic [IW-1:0] idx;
  // Scan from the farthest offset down so the nearest requester after last_i wins.
  always_comb begin
    sel_o   = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int i = N_CLIENTS; i >= 1; i--) begin
      idx = IW'((int'(last_i) + i) % N_CLIENTS);
      if (req_i[idx]) begin
        sel_o   = idx;
        valid_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: round-robin, transaction-level sharing of one SPI byte engine with CS guard times and idle watchdog
module spi_bus_arbiter
  import spi_bus_arbiter_pkg::*;
#(
  parameter int N_CLIENTS     = 2,
  parameter int CS_SETUP_CLKS = 4,
  parameter int CS_HOLD_CLKS  = 4,
  parameter int IDLE_TIMEOUT  = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_bus_arbiter_if.master    bus,
  output logic                 busy_o,
  output logic [N_CLIENTS-1:0] timeout_flag_o,
  input  logic [N_CLIENTS-1:0] clear_timeout_i
);
  localparam int IW = $clog2(N_CLIENTS);
  localparam int SW = cnt_w(CS_SETUP_CLKS > CS_HOLD_CLKS ? CS_SETUP_CLKS : CS_HOLD_CLKS);
  localparam int TW = cnt_w(IDLE_TIMEOUT);
  localparam logic [SW-1:0] SETUP_END = SW'(CS_SETUP_CLKS - 1);
  localparam logic [SW-1:0] HOLD_END  = SW'(CS_HOLD_CLKS - 1);
  localparam logic [TW-1:0] IDLE_END  = TW'(IDLE_TIMEOUT > 0 ? IDLE_TIMEOUT - 1 : 0);

  state_e               state_q, state_d;
  logic [N_CLIENTS-1:0] grant_q, grant_d;
  logic [N_CLIENTS-1:0] tflag_q, tflag_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [IW-1:0]        last_q, last_d;
  logic [SW-1:0]        cnt_q, cnt_d;
  logic [TW-1:0]        idle_q, idle_d;
  logic                 fly_q, fly_d;
  logic [IW-1:0]        pick_sel;
  logic                 pick_valid;
  logic                 own, tx_ok, wd_fire;

  rr_pick_n #(.N_CLIENTS(N_CLIENTS)) u_pick (
    .req_i   (bus.req),
    .last_i  (last_q),
    .sel_o   (pick_sel),
    .valid_o (pick_valid)
  );

  assign own              = state_q == ST_OWN;
  assign tx_ok            = own & bus.spi_tx_ready & bus.req[owner_q];
  assign bus.cli_tx_ready = tx_ok ? grant_q : '0;
  assign bus.spi_tx_dv    = tx_ok & bus.cli_tx_dv[owner_q];
  assign bus.spi_tx_byte  = bus.cli_tx_byte[owner_q];
  assign bus.cli_rx_dv    = ((own || state_q == ST_DRAIN) && bus.spi_rx_dv) ? grant_q : '0;
  assign bus.cli_rx_byte  = bus.spi_rx_byte;
  assign bus.grant        = grant_q;
  assign bus.cs_n         = ~grant_q;
  assign busy_o           = state_q != ST_IDLE;
  assign timeout_flag_o   = tflag_q;
  // A dropped req takes priority over the watchdog, so the flag is only raised while req is held.
  assign wd_fire = (IDLE_TIMEOUT > 0) && own && bus.req[owner_q] && !fly_q &&
                   !bus.spi_tx_dv && idle_q == IDLE_END;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    fly_d   = bus.spi_tx_dv | (fly_q & ~bus.spi_rx_dv);
    idle_d  = (!own || bus.spi_tx_dv) ? '0 :
              (!fly_q && idle_q != IDLE_END) ? idle_q + 1'b1 : idle_q;
    tflag_d = (tflag_q & ~clear_timeout_i) | (wd_fire ? grant_q : '0);
    case (state_q)
      ST_IDLE: if (pick_valid) begin
        state_d = ST_SETUP;
        grant_d = N_CLIENTS'(1) << pick_sel;
        owner_d = pick_sel;
        cnt_d   = '0;
      end
      ST_SETUP: if (cnt_q == SETUP_END) state_d = ST_OWN; else cnt_d = cnt_q + 1'b1;
      ST_OWN:   if (!bus.req[owner_q] || wd_fire) state_d = ST_DRAIN;
      ST_DRAIN: if (!fly_q && bus.spi_tx_ready) begin
        state_d = ST_HOLD;
        grant_d = '0;
        cnt_d   = '0;
        last_d  = owner_q;
      end
      ST_HOLD:  if (cnt_q == HOLD_END) state_d = ST_IDLE; else cnt_d = cnt_q + 1'b1;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      tflag_q <= '0;
      owner_q <= '0;
      last_q  <= IW'(N_CLIENTS - 1);
      cnt_q   <= '0;
      idle_q  <= '0;
      fly_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      tflag_q <= tflag_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      fly_q   <= fly_d;
    end
endmodule
